// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable synchronous down counter / interval timer with
// terminal-count pulse and optional auto-reload. Rev 1.0
`default_nettype none

module sync_down_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  input  logic         auto_reload,
  output logic [N-1:0] q,
  output logic         zero,
  output logic         tc_pulse,
  output logic         busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  localparam logic [N-1:0] C_ZERO = '0;
  localparam logic [N-1:0] C_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic [N-1:0] r_q;
  logic [N-1:0] r_reload;
  logic         r_tc;
  logic         w_last;

  // Only q==1 can be the last count: COUNT is never entered with q==0.
  assign w_last = (r_q == C_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_q      <= C_ZERO;
      r_reload <= C_ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (clear) begin
        r_q     <= C_ZERO;
        r_state <= S_IDLE;
      end else if (load) begin
        r_q      <= load_val;
        r_reload <= load_val;
        r_state  <= (load_val != C_ZERO) ? S_COUNT : S_IDLE;
      end else if ((r_state == S_COUNT) && en) begin
        if (!w_last) begin
          r_q <= r_q - C_ONE;
        end else begin
          r_tc <= 1'b1;
          if (auto_reload) begin
            r_q <= r_reload;
          end else begin
            r_q     <= C_ZERO;
            r_state <= S_IDLE;
          end
        end
      end
    end
  end

  assign q        = r_q;
  assign zero     = (r_q == C_ZERO);
  assign tc_pulse = r_tc;
  assign busy     = (r_state == S_COUNT);

endmodule

`default_nettype wire
